ram_wait_ctrl: RTL and testbench

//  Parametrised byte-addressable big-endian data/instruction RAM with a MOV/MOC handshake.

---
 rtl/ram_wait_ctrl.sv | 172 +++++++++++++++++
 tb/tb_ram_wait_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_wait_ctrl.sv
// ram_wait_ctrl: byte-addressable big-endian RAM behind a MOV/MOC handshake with programmable wait states.
// Build option `MEM_ALIGN_FAULT_EN: misaligned halfword/word accesses are suppressed and flagged on FAULT.
//
// state  | meaning
// IDLE   | waiting for MOV; request latched when MOV=1
// WAIT   | down-counting wait states, inputs ignored
// ACCESS | read/write on the latched request, MOC issued at the end of this cycle
// DONE   | handshake tail, waiting for MOV=0
module ram_wait_ctrl #(
    parameter int ADDR_W      = 8,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              MOV,
    input  logic              RW,
    input  logic [2:0]        MS,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [31:0]       DATA_IN,
    output logic [31:0]       DATA_OUT,
    output logic              MOC,
    output logic              BUSY,
    output logic              FAULT
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE} state_t;

    localparam logic [3:0]  WAIT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
    localparam int unsigned DEPTH_U   = DEPTH;

    state_t            state_q, state_d;
    logic [3:0]        wait_cnt_q, wait_cnt_d;
    logic              capture;
    logic              req_rw;
    logic [2:0]        req_ms;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_din;
    logic [31:0]       data_out_q;
    logic              moc_q;
    logic [7:0]        mem [0:DEPTH-1];

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        capture    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (MOV) begin
                    capture = 1'b1;
                    if (WAIT_STATES == 0) begin
                        state_d = S_ACCESS;
                    end else begin
                        state_d    = S_WAIT;
                        wait_cnt_d = WAIT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (wait_cnt_q == 4'd0) state_d = S_ACCESS;
                else                    wait_cnt_d = wait_cnt_q - 4'd1;
            end
            S_ACCESS: state_d = S_DONE;
            S_DONE:   if (!MOV) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    logic              is_byte, is_half, is_signed, do_access;
    logic [ADDR_W-1:0] base_addr, a0, a1, a2, a3;
    logic [7:0]        b0, b1, b2, b3;
    logic [31:0]       rd_data;

    assign is_byte   = (req_ms[1:0] == 2'b00);
    assign is_half   = (req_ms[1:0] == 2'b01);
    assign is_signed = req_ms[2] & ~req_ms[1];

`ifdef MEM_ALIGN_FAULT_EN
    logic misaligned;
    logic fault_q;
    assign misaligned = (is_half & req_addr[0]) |
                        (~is_byte & ~is_half & (req_addr[1:0] != 2'b00));
    assign base_addr  = req_addr;
    assign do_access  = ~misaligned;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) fault_q <= 1'b0;
        else        fault_q <= (state_q == S_ACCESS) && misaligned;
    end
    assign FAULT = fault_q;
`else
    // Misaligned requests are silently aligned down to their natural boundary.
    assign base_addr = is_byte ? req_addr :
                       is_half ? {req_addr[ADDR_W-1:1], 1'b0} :
                                 {req_addr[ADDR_W-1:2], 2'b00};
    assign do_access = 1'b1;
    assign FAULT     = 1'b0;
`endif

    function automatic logic [ADDR_W-1:0] byte_addr(input logic [ADDR_W-1:0] base,
                                                    input int unsigned       offset);
        int unsigned sum;
        sum = (32'(base) + offset) % DEPTH_U;
        return sum[ADDR_W-1:0];
    endfunction

    assign a0 = byte_addr(base_addr, 0);
    assign a1 = byte_addr(base_addr, 1);
    assign a2 = byte_addr(base_addr, 2);
    assign a3 = byte_addr(base_addr, 3);
    assign b0 = mem[a0];
    assign b1 = mem[a1];
    assign b2 = mem[a2];
    assign b3 = mem[a3];

    always_comb begin
        rd_data = {b0, b1, b2, b3};
        if (is_byte)      rd_data = {{24{is_signed & b0[7]}}, b0};
        else if (is_half) rd_data = {{16{is_signed & b0[7]}}, b0, b1};
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            moc_q      <= 1'b0;
            data_out_q <= '0;
            req_rw     <= 1'b0;
            req_ms     <= '0;
            req_addr   <= '0;
            req_din    <= '0;
        end else begin
            moc_q <= (state_q == S_ACCESS);
            if (capture) begin
                req_rw   <= RW;
                req_ms   <= MS;
                req_addr <= ADDR;
                req_din  <= DATA_IN;
            end
            if (state_q == S_ACCESS && req_rw && do_access) data_out_q <= rd_data;
        end
    end

    // The array is deliberately left out of reset; contents survive RESET.
    always_ff @(posedge CLK) begin
        if (state_q == S_ACCESS && !req_rw && do_access) begin
            if (is_byte) begin
                mem[a0] <= req_din[7:0];
            end else if (is_half) begin
                mem[a0] <= req_din[15:8];
                mem[a1] <= req_din[7:0];
            end else begin
                mem[a0] <= req_din[31:24];
                mem[a1] <= req_din[23:16];
                mem[a2] <= req_din[15:8];
                mem[a3] <= req_din[7:0];
            end
        end
    end

    assign DATA_OUT = data_out_q;
    assign MOC      = moc_q;
    assign BUSY     = (state_q == S_WAIT) || (state_q == S_ACCESS);

endmodule

// File: tb/tb_ram_wait_ctrl.sv
// Self-checking bench for ram_wait_ctrl: directed vector table, hand-written abort/handshake
// sequences and randomized transactions against a byte-array reference model.
module tb_ram_wait_ctrl;
    localparam int ADDR_W = 8;
    // DEPTH is not a multiple of 4 so an aligned word at DEPTH-2 straddles the wrap point.
    localparam int DEPTH  = 254;
    localparam int WS     = 2;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        MOV = 1'b0;
    logic        RW = 1'b0;
    logic [2:0]  MS = 3'b000;
    logic [7:0]  ADDR = '0;
    logic [31:0] DATA_IN = '0;
    logic [31:0] DATA_OUT;
    logic        MOC, BUSY, FAULT;

    ram_wait_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .WAIT_STATES(WS)) dut (
        .CLK(CLK), .RESET(RESET), .MOV(MOV), .RW(RW), .MS(MS), .ADDR(ADDR),
        .DATA_IN(DATA_IN), .DATA_OUT(DATA_OUT), .MOC(MOC), .BUSY(BUSY), .FAULT(FAULT)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    logic [7:0]  model_mem [DEPTH];
    logic [31:0] exp_data;
    logic        exp_fault;

    typedef struct {
        logic        rw;
        logic [2:0]  ms;
        logic [7:0]  addr;
        logic [31:0] din;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    function automatic void add(input logic rw, input logic [2:0] ms, input logic [7:0] addr,
                                input logic [31:0] din, input logic [31:0] exp);
        vec_t v;
        v.rw = rw; v.ms = ms; v.addr = addr; v.din = din; v.exp = exp;
        tbl.push_back(v);
    endfunction

    // Reference: size in bytes, big-endian accumulation, arithmetic sign extension.
    function automatic void model_access(input logic rw, input logic [2:0] ms,
                                         input logic [7:0] addr, input logic [31:0] din);
        int     n;
        int     base;
        bit     sgn;
        bit     mis;
        longint val;
        n    = (ms[1:0] == 2'b00) ? 1 : (ms[1:0] == 2'b01) ? 2 : 4;
        sgn  = (ms == 3'b100) || (ms == 3'b101);
        base = int'(addr);
        mis  = (base % n) != 0;
`ifdef MEM_ALIGN_FAULT_EN
        exp_fault = mis;
        if (mis) return;
`else
        exp_fault = 1'b0;
        base = base - (base % n);
`endif
        if (rw) begin
            val = 0;
            for (int i = 0; i < n; i++) val = val * 256 + longint'(model_mem[(base + i) % DEPTH]);
            if (sgn && val >= (64'sd1 <<< (8 * n - 1))) val = val - (64'sd1 <<< (8 * n));
            exp_data = 32'(val);
        end else begin
            for (int i = 0; i < n; i++)
                model_mem[(base + i) % DEPTH] = 8'((din >> (8 * (n - 1 - i))) & 32'hFF);
        end
    endfunction

    task automatic txn(input logic rw, input logic [2:0] ms, input logic [7:0] addr,
                       input logic [31:0] din, input int hold, input bit drop_early);
        model_access(rw, ms, addr, din);
        @(negedge CLK);
        MOV = 1'b1; RW = rw; MS = ms; ADDR = addr; DATA_IN = din;
        @(posedge CLK); #1;
        chk("busy_after_capture", 32'(BUSY), 32'd1);
        if (drop_early) MOV = 1'b0;
        RW = 1'($urandom); MS = 3'($urandom); ADDR = 8'($urandom); DATA_IN = $urandom;
        for (int k = 1; k <= WS + 1; k++) begin
            @(posedge CLK); #1;
            chk("moc_timing", 32'(MOC), 32'(k == WS + 1));
            chk("busy_timing", 32'(BUSY), 32'(k != WS + 1));
        end
        chk("data_out", DATA_OUT, exp_data);
        chk("fault", 32'(FAULT), 32'(exp_fault));
        for (int h = 0; h < hold; h++) begin
            @(posedge CLK); #1;
            chk("moc_held_mov", 32'(MOC), 32'd0);
        end
        MOV = 1'b0;
        @(posedge CLK); #1;
        chk("moc_pulse_end", 32'(MOC), 32'd0);
        chk("busy_done", 32'(BUSY), 32'd0);
    endtask

    task automatic abort_txn(input logic [7:0] addr, input logic [31:0] din, input int extra_edges);
        @(negedge CLK);
        MOV = 1'b1; RW = 1'b0; MS = 3'b010; ADDR = addr; DATA_IN = din;
        @(posedge CLK);
        repeat (extra_edges) @(posedge CLK);
        #1;
        RESET = 1'b0;
        MOV = 1'b0;
        #1;
        chk("abort_moc", 32'(MOC), 32'd0);
        chk("abort_busy", 32'(BUSY), 32'd0);
        chk("abort_data_out", DATA_OUT, 32'd0);
        chk("abort_fault", 32'(FAULT), 32'd0);
        exp_data = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
        for (int k = 0; k < WS + 3; k++) begin
            @(posedge CLK); #1;
            chk("abort_no_moc", 32'(MOC), 32'd0);
        end
    endtask

    initial begin
        exp_data  = '0;
        exp_fault = 1'b0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;

        #12;
        chk("rst_moc", 32'(MOC), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_fault", 32'(FAULT), 32'd0);
        chk("rst_data_out", DATA_OUT, 32'd0);
        @(negedge CLK);
        RESET = 1'b1;

        // Bring the array to a known all-zero state through the port.
        for (int a = 0; a < DEPTH; a += 4) txn(1'b0, 3'b010, 8'(a), 32'd0, 0, 1'b0);

        add(0, 3'b000, 8'h00, 32'hE3, 'x);
        add(0, 3'b000, 8'h01, 32'hA0, 'x);
        add(0, 3'b000, 8'h02, 32'h10, 'x);
        add(0, 3'b000, 8'h03, 32'h05, 'x);
        add(1, 3'b010, 8'h00, 'x, 32'hE3A01005);
        add(0, 3'b010, 8'h04, 32'h12345678, 'x);
        add(1, 3'b100, 8'h07, 'x, 32'h00000078);
        add(1, 3'b101, 8'h04, 'x, 32'h00001234);
        add(1, 3'b011, 8'h04, 'x, 32'h12345678);
        add(0, 3'b000, 8'h08, 32'hFFFFFF80, 'x);
        add(1, 3'b100, 8'h08, 'x, 32'hFFFFFF80);
        add(1, 3'b000, 8'h08, 'x, 32'h00000080);
        add(1, 3'b101, 8'h08, 'x, 32'hFFFF8000);
        add(0, 3'b100, 8'h09, 32'h0000AB7F, 'x);
        add(1, 3'b001, 8'h08, 'x, 32'h0000807F);
        add(0, 3'b000, 8'd252, 32'hAA, 'x);
        add(0, 3'b000, 8'd253, 32'hBB, 'x);
        add(0, 3'b000, 8'd0, 32'hCC, 'x);
        add(0, 3'b000, 8'd1, 32'hDD, 'x);
        add(1, 3'b010, 8'd252, 'x, 32'hAABBCCDD);
        add(1, 3'b101, 8'd252, 'x, 32'hFFFFAABB);
        add(0, 3'b010, 8'h20, 32'hDEADBEEF, 'x);
        add(1, 3'b110, 8'h20, 'x, 32'hDEADBEEF);
        add(1, 3'b001, 8'h08, 'x, 32'h0000807F);
`ifdef MEM_ALIGN_FAULT_EN
        add(1, 3'b010, 8'h21, 'x, 32'h0000807F);
`else
        add(1, 3'b010, 8'h21, 'x, 32'hDEADBEEF);
`endif

        for (int i = 0; i < tbl.size(); i++) begin
            txn(tbl[i].rw, tbl[i].ms, tbl[i].addr, tbl[i].din, 0, 1'b0);
            if (tbl[i].rw) chk($sformatf("tbl%0d_data", i), DATA_OUT, tbl[i].exp);
        end

        // MOV held high after MOC, then MOV dropped during WAIT.
        txn(1'b1, 3'b010, 8'h04, 'x, 5, 1'b0);
        chk("hold_data", DATA_OUT, 32'h12345678);
        txn(1'b1, 3'b010, 8'h20, 'x, 0, 1'b1);
        chk("drop_data", DATA_OUT, 32'hDEADBEEF);

        // Reset during WAIT and during ACCESS: no write, no MOC.
        abort_txn(8'h10, 32'h11223344, 0);
        txn(1'b1, 3'b010, 8'h10, 'x, 0, 1'b0);
        chk("abort_wait_old", DATA_OUT, 32'h00000000);
        abort_txn(8'h10, 32'h55667788, WS);
        txn(1'b1, 3'b010, 8'h10, 'x, 0, 1'b0);
        chk("abort_access_old", DATA_OUT, 32'h00000000);

        for (int r = 0; r < 300; r++) begin
            logic [7:0] ra;
            ra = ($urandom_range(1) == 0) ? 8'($urandom_range(15)) : 8'($urandom_range(DEPTH - 1));
            txn(1'($urandom), 3'($urandom), ra, $urandom, int'($urandom_range(2)),
                1'($urandom_range(3) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
